sampler_request_gen: RTL and testbench

//  Initiator side of the tree-sampler interface. Collects one token's per-topic
//  (probability, topic) beats from the upstream scoring stream and packs them into the

---
 rtl/sampler_request_gen_if.sv | 38 +++
 rtl/sampler_request_gen.sv | 158 +++++++++++++++
 tb/tb_sampler_request_gen.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sampler_request_gen_if.sv
// Signal bundle between sampler_request_gen (master view) and its environment:
// upstream beat stream, flat sampler request buses, sampler done/result and result stream.
interface sampler_request_gen_if #(
    parameter int NUM_TOPICS     = 16,
    parameter int NUM_TOPICS_LOG = 4
);
    logic                         s_valid;
    logic                         s_ready;
    logic [31:0]                  s_prob;
    logic [31:0]                  s_topic;
    logic                         s_last;

    logic [31:0]                  o_ntopic;
    logic [NUM_TOPICS*32-1:0]     o_probs;
    logic [NUM_TOPICS*32-1:0]     o_topics;
    logic [NUM_TOPICS-1:0]        o_valid;
    logic [NUM_TOPICS_LOG*32-1:0] o_random;
    logic                         o_start;
    logic                         i_done;
    logic [31:0]                  i_new_topic;

    logic                         m_valid;
    logic                         m_ready;
    logic [31:0]                  m_topic;
    logic                         m_err;

    modport master (
        input  s_valid, s_prob, s_topic, s_last, i_done, i_new_topic, m_ready,
        output s_ready, o_ntopic, o_probs, o_topics, o_valid, o_random, o_start,
               m_valid, m_topic, m_err
    );

    modport slave (
        output s_valid, s_prob, s_topic, s_last, i_done, i_new_topic, m_ready,
        input  s_ready, o_ntopic, o_probs, o_topics, o_valid, o_random, o_start,
               m_valid, m_topic, m_err
    );
endinterface

// File: rtl/sampler_request_gen.sv
// Tree-sampler initiator: packs one token's beats into flat slots, issues a start with
// fresh per-layer LFSR words, waits for done and returns the topic. SAMPLER_TIMEOUT_EN adds a WAIT watchdog.
module sampler_request_gen #(
    parameter int          NUM_TOPICS     = 16,
    parameter int          NUM_TOPICS_LOG = 4,
    parameter logic [31:0] SEED           = 32'h1ACE5EED,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sampler_request_gen_if.master bus
);

    typedef enum logic [2:0] {
        ST_LOAD, ST_ISSUE, ST_WAIT, ST_SETTLE, ST_RESULT
    } state_t;

    localparam int          CNT_W     = NUM_TOPICS_LOG + 1;
    localparam logic [31:0] LFSR_MASK = 32'h80200003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? LFSR_MASK : 32'h0);
    endfunction

    // A zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [31:0] seed_of(input int j);
        logic [31:0] s;
        s = SEED + 32'(j);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         count_q;
    logic [NUM_TOPICS*32-1:0] probs_q, topics_q;
    logic [NUM_TOPICS-1:0]    valid_q;
    logic [31:0]              ntopic_q;
    logic [31:0]              m_topic_q;
    logic                     m_err_q;
    logic                     beat_fire;
    logic                     timeout_hit;
    logic [NUM_TOPICS_LOG-1:0] slot_idx;

    assign slot_idx = count_q[NUM_TOPICS_LOG-1:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d   = state_q;
        beat_fire = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (bus.s_valid) begin
                    beat_fire = 1'b1;
                    if (bus.s_last || count_q == CNT_W'(NUM_TOPICS - 1))
                        state_d = ST_ISSUE;
                end
            end
            ST_ISSUE:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.i_done)
                    state_d = ST_SETTLE;
                else if (timeout_hit)
                    state_d = ST_RESULT;
            end
            ST_SETTLE: state_d = ST_RESULT;
            ST_RESULT: if (bus.m_ready) state_d = ST_LOAD;
            default:   state_d = ST_LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the slot buses are
    // reset explicitly because unloaded slots must read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_LOAD;
            count_q   <= '0;
            probs_q   <= '0;
            topics_q  <= '0;
            valid_q   <= '0;
            ntopic_q  <= '0;
            m_topic_q <= '0;
            m_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_LOAD: begin
                    if (beat_fire) begin
                        probs_q[32*slot_idx +: 32]  <= bus.s_prob;
                        topics_q[32*slot_idx +: 32] <= bus.s_topic;
                        valid_q[slot_idx]           <= 1'b1;
                        count_q                     <= count_q + CNT_W'(1);
                        if (state_d == ST_ISSUE)
                            ntopic_q <= 32'(count_q) + 32'd1;
                    end
                end
                ST_WAIT: begin
                    if (timeout_hit) begin
                        m_topic_q <= '0;
                        m_err_q   <= 1'b1;
                    end
                end
                ST_SETTLE: m_topic_q <= bus.i_new_topic;
                ST_RESULT: begin
                    if (bus.m_ready) begin
                        probs_q  <= '0;
                        topics_q <= '0;
                        valid_q  <= '0;
                        ntopic_q <= '0;
                        count_q  <= '0;
                        m_err_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar j = 0; j < NUM_TOPICS_LOG; j++) begin : g_lfsr
        logic [31:0] lfsr_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                lfsr_q <= seed_of(j);
            else if (state_q == ST_ISSUE)
                lfsr_q <= lfsr_step(lfsr_q);
        end
        assign bus.o_random[32*j +: 32] = lfsr_q;
    end

`ifdef SAMPLER_TIMEOUT_EN
    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WCNT_W-1:0] wait_cnt_q;

    // Counter is 0 on the first WAIT cycle, so the abort lands TIMEOUT_CYCLES after entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt_q <= '0;
        else if (state_q == ST_WAIT)
            wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
        else
            wait_cnt_q <= '0;
    end

    assign timeout_hit = (state_q == ST_WAIT) && !bus.i_done &&
                         (wait_cnt_q == WCNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign bus.s_ready  = (state_q == ST_LOAD);
    assign bus.o_start  = (state_q == ST_WAIT);
    assign bus.m_valid  = (state_q == ST_RESULT);
    assign bus.m_topic  = m_topic_q;
    assign bus.m_err    = m_err_q;
    assign bus.o_ntopic = ntopic_q;
    assign bus.o_probs  = probs_q;
    assign bus.o_topics = topics_q;
    assign bus.o_valid  = valid_q;

endmodule

// File: tb/tb_sampler_request_gen.sv
// Self-checking bench for sampler_request_gen: table-driven tokens plus hand-written
// corner sequences, results checked through a scoreboard queue.
module tb_sampler_request_gen;

  localparam int          NT   = 16;
  localparam int          NL   = 4;
  localparam logic [31:0] SEED = 32'h1ACE5EED;
  localparam int          TO   = 64;

  typedef struct {
    int          nbeats;
    int          last_idx;
    logic [31:0] prob_base;
    logic [31:0] topic_base;
    logic [31:0] new_topic;
    int          ready_delay;
    logic [31:0] exp_ntopic;
    logic [15:0] exp_valid;
  } vec_t;

  typedef struct {
    logic [31:0] topic;
    logic        err;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sampler_request_gen_if #(.NUM_TOPICS(NT), .NUM_TOPICS_LOG(NL)) bus ();

  sampler_request_gen #(
    .NUM_TOPICS(NT), .NUM_TOPICS_LOG(NL), .SEED(SEED), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  int          total = 0;
  int          bad = 0;
  res_t        sb[$];
  logic [31:0] lfsr_m[NL];
  vec_t        vecs[5];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_step(input logic [31:0] x);
    return (x >> 1) ^ ({32{x[0]}} & 32'h80200003);
  endfunction

  task automatic model_reset();
    logic [31:0] s;
    for (int j = 0; j < NL; j++) begin
      s = SEED + j;
      lfsr_m[j] = (s == 0) ? 32'd1 : s;
    end
  endtask

  task automatic model_advance();
    for (int j = 0; j < NL; j++) lfsr_m[j] = model_step(lfsr_m[j]);
  endtask

  task automatic check_random(input string name);
    logic [NL*32-1:0] er;
    for (int j = 0; j < NL; j++) er[32*j +: 32] = lfsr_m[j];
    check(name, bus.o_random, er);
  endtask

  task automatic send_beat(input logic [31:0] prob, input logic [31:0] topic, input logic last);
    int k;
    bus.s_valid = 1'b1;
    bus.s_prob  = prob;
    bus.s_topic = topic;
    bus.s_last  = last;
    k = 0;
    while (!bus.s_ready && k < 200) begin
      tick();
      k++;
    end
    check("s_ready_wait", bus.s_ready, 1'b1);
    tick();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // WAIT -> SETTLE -> RESULT; i_new_topic is scrambled after capture to prove it was held.
  task automatic issue_done(input logic [31:0] topic);
    bus.i_done      = 1'b1;
    bus.i_new_topic = topic;
    sb.push_back('{topic, 1'b0});
    tick();
    bus.i_done = 1'b0;
    check("settle_m_valid", bus.m_valid, 1'b0);
    check("settle_o_start", bus.o_start, 1'b0);
    tick();
    bus.i_new_topic = 32'hDEADBEEF;
    check("result_m_valid", bus.m_valid, 1'b1);
  endtask

  task automatic collect(input int delay);
    res_t r;
    for (int i = 0; i < delay; i++) begin
      check("stall_m_valid", bus.m_valid, 1'b1);
      if (sb.size() > 0) check("stall_m_topic", bus.m_topic, sb[0].topic);
      check("stall_s_ready", bus.s_ready, 1'b0);
      tick();
    end
    bus.m_ready = 1'b1;
    check("hs_m_valid", bus.m_valid, 1'b1);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got result %0h expected none", bus.m_topic);
    end else begin
      r = sb.pop_front();
      check("m_topic", bus.m_topic, r.topic);
      check("m_err", bus.m_err, r.err);
    end
    tick();
    bus.m_ready = 1'b0;
    check("post_m_valid", bus.m_valid, 1'b0);
    check("post_s_ready", bus.s_ready, 1'b1);
    check("post_o_start", bus.o_start, 1'b0);
    check("post_ntopic", bus.o_ntopic, 32'd0);
    check("post_valid", bus.o_valid, 16'h0);
  endtask

  task automatic run_token(input vec_t v);
    logic [NT*32-1:0] ep, et;
    ep = '0;
    et = '0;
    for (int i = 0; i < v.nbeats; i++) begin
      send_beat(v.prob_base + i, v.topic_base + i, i == v.last_idx);
      ep[32*i +: 32] = v.prob_base + i;
      et[32*i +: 32] = v.topic_base + i;
    end
    check("issue_o_start", bus.o_start, 1'b0);
    check("issue_s_ready", bus.s_ready, 1'b0);
    check("ntopic", bus.o_ntopic, v.exp_ntopic);
    check("valid", bus.o_valid, v.exp_valid);
    check("probs", bus.o_probs, ep);
    check("topics", bus.o_topics, et);
    model_advance();
    tick();
    check("wait_o_start", bus.o_start, 1'b1);
    check_random("o_random");
    issue_done(v.new_topic);
    collect(v.ready_delay);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [NT*32-1:0] ep;

    vecs[0] = '{16, 15,  32'd1, 32'd100, 32'd107,  0, 32'd16, 16'hFFFF};
    vecs[1] = '{ 5,  4, 32'd10,  32'd40,   32'd3,  0,  32'd5, 16'h001F};
    vecs[2] = '{ 3,  2, 32'd50,  32'd60,  32'd12, 10,  32'd3, 16'h0007};
    vecs[3] = '{ 1,  0,  32'd9,   32'd1,  32'd15,  1,  32'd1, 16'h0001};
    vecs[4] = '{16, -1, 32'd500, 32'd600,  32'd0,  0, 32'd16, 16'hFFFF};

    bus.s_valid = 1'b0; bus.s_prob = '0; bus.s_topic = '0; bus.s_last = 1'b0;
    bus.i_done = 1'b0; bus.i_new_topic = '0; bus.m_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", bus.s_ready, 1'b1);
    check("rst_o_start", bus.o_start, 1'b0);
    check("rst_m_valid", bus.m_valid, 1'b0);
    check("rst_m_err", bus.m_err, 1'b0);
    check("rst_m_topic", bus.m_topic, 32'd0);
    check("rst_ntopic", bus.o_ntopic, 32'd0);
    check("rst_valid", bus.o_valid, 16'h0);
    check("rst_probs", bus.o_probs, '0);
    check_random("rst_o_random");
    rst_n = 1'b1;
    tick();

    // i_done outside WAIT must be ignored
    bus.i_done = 1'b1;
    tick();
    tick();
    bus.i_done = 1'b0;
    check("stray_done_m_valid", bus.m_valid, 1'b0);
    check("stray_done_s_ready", bus.s_ready, 1'b1);

    for (int i = 0; i < 5; i++) run_token(vecs[i]);

    // 17 beats without s_last: beat 17 waits and becomes slot 0 of the next token
    for (int i = 0; i < 16; i++) send_beat(200 + i, 300 + i, 1'b0);
    check("b17_ntopic", bus.o_ntopic, 32'd16);
    model_advance();
    bus.s_valid = 1'b1; bus.s_prob = 32'd777; bus.s_topic = 32'd888; bus.s_last = 1'b1;
    check("b17_s_ready", bus.s_ready, 1'b0);
    tick();
    check("b17_o_start", bus.o_start, 1'b1);
    check("b17_not_consumed", bus.o_valid, 16'hFFFF);
    check_random("b17_o_random");
    issue_done(32'd55);
    collect(0);
    tick();
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    ep = '0;
    ep[31:0] = 32'd777;
    check("b17_slot0_valid", bus.o_valid, 16'h0001);
    check("b17_slot0_ntopic", bus.o_ntopic, 32'd1);
    check("b17_slot0_probs", bus.o_probs, ep);
    model_advance();
    tick();
    check("b17b_o_start", bus.o_start, 1'b1);
    check_random("b17b_o_random");
    issue_done(32'd3);
    collect(2);

    // sampler never answers
    send_beat(32'd4, 32'd70, 1'b0);
    send_beat(32'd5, 32'd71, 1'b1);
    model_advance();
    tick();
    check("to_o_start", bus.o_start, 1'b1);
`ifdef SAMPLER_TIMEOUT_EN
    repeat (TO - 1) tick();
    check("to_before_m_valid", bus.m_valid, 1'b0);
    check("to_before_o_start", bus.o_start, 1'b1);
    sb.push_back('{32'd0, 1'b1});
    tick();
    check("to_m_valid", bus.m_valid, 1'b1);
    check("to_o_start_low", bus.o_start, 1'b0);
    collect(0);
`else
    repeat (1000) tick();
    check("nto_o_start", bus.o_start, 1'b1);
    check("nto_m_valid", bus.m_valid, 1'b0);
    check("nto_m_err", bus.m_err, 1'b0);
    issue_done(32'd9);
    collect(0);
`endif

    // reset pulse during WAIT
    send_beat(32'd6, 32'd80, 1'b0);
    send_beat(32'd7, 32'd81, 1'b0);
    send_beat(32'd8, 32'd82, 1'b1);
    tick();
    check("mid_o_start", bus.o_start, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mrst_o_start", bus.o_start, 1'b0);
    check("mrst_m_valid", bus.m_valid, 1'b0);
    check("mrst_valid", bus.o_valid, 16'h0);
    check("mrst_ntopic", bus.o_ntopic, 32'd0);
    check("mrst_s_ready", bus.s_ready, 1'b1);
    check_random("mrst_o_random");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_token(vecs[1]);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
